// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: each ROM word selects the next microstate via J/COND/IRD
// and carries the datapath control word; adds a BEN register and a memory-ready timeout.
module lc3_microsequencer #(
    parameter int    CTRL_W      = 26,
    parameter int    STATE_W     = 6,
    parameter string ROM_FILE    = "microcode.bin",
    parameter int    RESET_STATE = 18,
    parameter int    FAULT_STATE = 34,
    parameter int    LD_BEN_BIT  = 22,
    parameter int    MEM_TIMEOUT = 0,
    parameter logic [(2**STATE_W)*(CTRL_W+STATE_W+4)-1:0] ROM_INIT = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [15:0]       ir_i,
    input  logic              r_i,
    input  logic              n_i,
    input  logic              z_i,
    input  logic              p_i,
    input  logic              psr_priv_i,
    input  logic              int_req_i,
    output logic [CTRL_W-1:0] control_out_o,
    output logic [STATE_W-1:0] state_o,
    output logic              ben_o,
    output logic              mem_fault_o
);

    localparam int DEPTH = 2**STATE_W;
    localparam int ROM_W = CTRL_W + STATE_W + 4;
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [2:0] COND_R    = 3'b001;
    localparam logic [2:0] COND_BEN  = 3'b010;
    localparam logic [2:0] COND_ADDR = 3'b011;
    localparam logic [2:0] COND_PSR  = 3'b100;
    localparam logic [2:0] COND_INT  = 3'b101;

    logic [ROM_W-1:0]   rom [DEPTH];

    logic [STATE_W-1:0] state_q, state_d;
    logic [ROM_W-1:0]   word_q;
    logic               ben_q;
    logic               mem_fault_q, mem_fault_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic               ird_w;
    logic [2:0]         cond_w;
    logic [STATE_W-1:0] j_w;
    logic               unused_ir;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_word
            assign rom[i] = ROM_INIT[i*ROM_W +: ROM_W];
        end
    endgenerate

    assign ird_w     = word_q[ROM_W-1];
    assign cond_w    = word_q[ROM_W-2 -: 3];
    assign j_w       = word_q[CTRL_W +: STATE_W];
    assign unused_ir = ^ir_i[8:0];

    always_comb begin
        state_d     = j_w;
        mem_fault_d = 1'b0;
        wait_cnt_d  = '0;
        if (ird_w) begin
            state_d = STATE_W'(ir_i[15:12]);
        end else begin
            case (cond_w)
                COND_R:    state_d = j_w | (STATE_W'(r_i) << 1);
                COND_BEN:  state_d = j_w | (STATE_W'(ben_q) << 2);
                COND_ADDR: state_d = j_w | STATE_W'(ir_i[11]);
                COND_PSR:  state_d = j_w | (STATE_W'(psr_priv_i) << 3);
                COND_INT:  state_d = j_w | (STATE_W'(int_req_i) << 4);
                default:   state_d = j_w;
            endcase
            // The counter saturates at MEM_TIMEOUT-1; the next stalled edge faults instead of wrapping.
            if ((MEM_TIMEOUT > 0) && (cond_w == COND_R) && !r_i) begin
                if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d     = STATE_W'(FAULT_STATE);
                    mem_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        end
    end

    // The ROM word is fetched with the next state so control_out never sees a ROM read path.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= STATE_W'(RESET_STATE);
            word_q      <= rom[STATE_W'(RESET_STATE)];
            ben_q       <= 1'b0;
            mem_fault_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= rom[state_d];
            mem_fault_q <= mem_fault_d;
            wait_cnt_q  <= wait_cnt_d;
            if (word_q[LD_BEN_BIT]) begin
                ben_q <= (ir_i[11] & n_i) | (ir_i[10] & z_i) | (ir_i[9] & p_i);
            end
        end
    end

    assign control_out_o = word_q[CTRL_W-1:0];
    assign state_o       = state_q;
    assign ben_o         = ben_q;
    assign mem_fault_o   = mem_fault_q;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Bench for lc3_microsequencer: two instances (timeout off / timeout 4) share inputs and a
// test microprogram; expected microstate sequences are queued per step and compared on pop.
module tb_lc3_microsequencer;

    localparam int CTRL_W  = 26;
    localparam int STATE_W = 6;
    localparam int DEPTH   = 64;
    localparam int ROM_W   = CTRL_W + STATE_W + 4;

    typedef struct {
        logic [5:0] st0;
        logic [5:0] st4;
        logic       ben;
        logic       f0;
        logic       f4;
    } exp_t;

    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [5:0] s);
        logic [31:0]       v;
        logic [CTRL_W-1:0] c;
        v = 32'(s) * 32'h10101 + 32'd3;
        c = v[CTRL_W-1:0];
        if (s == 6'd2) c[22] = 1'b1;
        return c;
    endfunction

    // Test microprogram: 18 -> 32 (dispatch); each opcode state leads into one branch scenario.
    function automatic logic [ROM_W-1:0] word_of(input int s);
        logic       ird;
        logic [2:0] c;
        logic [5:0] j;
        ird = 1'b0; c = 3'b000; j = 6'd18;
        case (s)
            1:  j = 6'd32;
            2:  j = 6'd40;
            3:  j = 6'd33;
            5:  j = 6'd41;
            6:  j = 6'd42;
            7:  j = 6'd43;
            9:  j = 6'd44;
            18: j = 6'd32;
            32: ird = 1'b1;
            33: begin c = 3'b001; j = 6'd33; end
            40: begin c = 3'b010; j = 6'd0;  end
            41: begin c = 3'b101; j = 6'd0;  end
            42: begin c = 3'b100; j = 6'd0;  end
            43: begin c = 3'b011; j = 6'd0;  end
            44: begin c = 3'b110; j = 6'd18; end
            default: ;
        endcase
        return {ird, c, j, ctrl_of(6'(s))};
    endfunction

    function automatic logic [DEPTH*ROM_W-1:0] build_rom();
        logic [DEPTH*ROM_W-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) img[i*ROM_W +: ROM_W] = word_of(i);
        return img;
    endfunction

    localparam logic [DEPTH*ROM_W-1:0] ROM_IMG = build_rom();

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       ir = '0;
    logic              r = 1'b0, n = 1'b0, z = 1'b0, p = 1'b0, priv = 1'b0, intr = 1'b0;
    logic [CTRL_W-1:0] co0, co4;
    logic [5:0]        st0, st4;
    logic              ben0, ben4, f0, f4;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lc3_microsequencer #(.ROM_FILE(""), .MEM_TIMEOUT(0), .ROM_INIT(ROM_IMG)) dut0 (
        .clk_i(clk), .reset_i(reset), .ir_i(ir), .r_i(r), .n_i(n), .z_i(z), .p_i(p),
        .psr_priv_i(priv), .int_req_i(intr),
        .control_out_o(co0), .state_o(st0), .ben_o(ben0), .mem_fault_o(f0));

    lc3_microsequencer #(.ROM_FILE(""), .MEM_TIMEOUT(4), .ROM_INIT(ROM_IMG)) dut4 (
        .clk_i(clk), .reset_i(reset), .ir_i(ir), .r_i(r), .n_i(n), .z_i(z), .p_i(p),
        .psr_priv_i(priv), .int_req_i(intr),
        .control_out_o(co4), .state_o(st4), .ben_o(ben4), .mem_fault_o(f4));

    function automatic exp_t mk(input int a, input int b, input int bn, input int x0, input int x4);
        exp_t e;
        e.st0 = 6'(a); e.st4 = 6'(b); e.ben = 1'(bn); e.f0 = 1'(x0); e.f4 = 1'(x4);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ir = '0; r = 1'b0; n = 1'b0; z = 1'b0; p = 1'b0; priv = 1'b0; intr = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_inputs();
        ir = 16'h3000;
        reset = 1'b1;
        sb.push_back(mk(18, 18, 0, 0, 0));
        tick();
        tick();
        e = sb.pop_front();
        checks++; if (st0 !== e.st0) begin failures++; $display("FAIL reset state0 got %0d exp %0d", st0, e.st0); end
        checks++; if (co0 !== ctrl_of(e.st0)) begin failures++; $display("FAIL reset ctrl0 got %h exp %h", co0, ctrl_of(e.st0)); end
        checks++; if (ben0 !== e.ben) begin failures++; $display("FAIL reset ben0 got %b exp %b", ben0, e.ben); end
        checks++; if (f0 !== e.f0) begin failures++; $display("FAIL reset fault0 got %b exp %b", f0, e.f0); end
        checks++; if (st4 !== e.st4) begin failures++; $display("FAIL reset state4 got %0d exp %0d", st4, e.st4); end
        checks++; if (co4 !== ctrl_of(e.st4)) begin failures++; $display("FAIL reset ctrl4 got %h exp %h", co4, ctrl_of(e.st4)); end
        checks++; if (ben4 !== e.ben) begin failures++; $display("FAIL reset ben4 got %b exp %b", ben4, e.ben); end
        checks++; if (f4 !== e.f4) begin failures++; $display("FAIL reset fault4 got %b exp %b", f4, e.f4); end
        reset = 1'b0;
    endtask

    task automatic test_dispatch();
        int   seq [5] = '{32, 1, 32, 15, 18};
        exp_t e;
        clear_inputs();
        ir = 16'h1042;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) ir = 16'hF025;
            sb.push_back(mk(seq[k], seq[k], 0, 0, 0));
            tick();
            e = sb.pop_front();
            checks++; if (st0 !== e.st0) begin failures++; $display("FAIL dispatch step %0d state0 got %0d exp %0d", k, st0, e.st0); end
            checks++; if (co0 !== ctrl_of(e.st0)) begin failures++; $display("FAIL dispatch step %0d ctrl0 got %h exp %h", k, co0, ctrl_of(e.st0)); end
            checks++; if (st4 !== e.st4) begin failures++; $display("FAIL dispatch step %0d state4 got %0d exp %0d", k, st4, e.st4); end
            checks++; if (f0 !== e.f0 || f4 !== e.f4) begin failures++; $display("FAIL dispatch step %0d fault got %b%b exp %b%b", k, f0, f4, e.f0, e.f4); end
        end
    endtask

    task automatic test_ben();
        int   seq [5];
        int   bseq [5];
        int   b;
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            ir = 16'h2400;
            z  = (c == 0);
            n  = (c == 1);
            b  = (c == 0) ? 1 : 0;
            seq  = '{32, 2, 40, (b != 0) ? 4 : 0, 18};
            bseq = '{0, 0, b, b, b};
            apply_reset();
            for (int k = 0; k < 5; k++) begin
                sb.push_back(mk(seq[k], seq[k], bseq[k], 0, 0));
                tick();
                e = sb.pop_front();
                checks++; if (st0 !== e.st0) begin failures++; $display("FAIL ben case %0d step %0d state0 got %0d exp %0d", c, k, st0, e.st0); end
                checks++; if (co0 !== ctrl_of(e.st0)) begin failures++; $display("FAIL ben case %0d step %0d ctrl0 got %h exp %h", c, k, co0, ctrl_of(e.st0)); end
                checks++; if (ben0 !== e.ben) begin failures++; $display("FAIL ben case %0d step %0d ben0 got %b exp %b", c, k, ben0, e.ben); end
                checks++; if (st4 !== e.st4 || ben4 !== e.ben) begin failures++; $display("FAIL ben case %0d step %0d dut4 got %0d/%b exp %0d/%b", c, k, st4, ben4, e.st4, e.ben); end
            end
        end
    endtask

    task automatic test_ready_wait();
        int   s0 [10] = '{32, 3, 33, 33, 33, 33, 33, 33, 35, 18};
        int   s4 [10] = '{32, 3, 33, 33, 33, 33, 34, 18, 32, 3};
        exp_t e;
        clear_inputs();
        ir = 16'h3000;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            r = (k >= 8);
            sb.push_back(mk(s0[k], s4[k], 0, 0, (k == 6) ? 1 : 0));
            tick();
            e = sb.pop_front();
            checks++; if (st0 !== e.st0) begin failures++; $display("FAIL ready_wait step %0d state0 got %0d exp %0d", k, st0, e.st0); end
            checks++; if (co0 !== ctrl_of(e.st0)) begin failures++; $display("FAIL ready_wait step %0d ctrl0 got %h exp %h", k, co0, ctrl_of(e.st0)); end
            checks++; if (f0 !== e.f0) begin failures++; $display("FAIL ready_wait step %0d fault0 got %b exp %b", k, f0, e.f0); end
            checks++; if (st4 !== e.st4) begin failures++; $display("FAIL ready_wait step %0d state4 got %0d exp %0d", k, st4, e.st4); end
            checks++; if (co4 !== ctrl_of(e.st4)) begin failures++; $display("FAIL ready_wait step %0d ctrl4 got %h exp %h", k, co4, ctrl_of(e.st4)); end
            checks++; if (f4 !== e.f4) begin failures++; $display("FAIL ready_wait step %0d fault4 got %b exp %b", k, f4, e.f4); end
        end
    endtask

    task automatic test_timeout();
        int   a  [8]  = '{32, 3, 33, 33, 33, 33, 35, 18};
        int   b0 [14] = '{32, 3, 33, 33, 33, 18, 32, 3, 33, 33, 33, 33, 33, 35};
        int   b4 [14] = '{32, 3, 33, 33, 33, 18, 32, 3, 33, 33, 33, 33, 34, 18};
        exp_t e;
        // R arrives on the would-be timeout edge: ready wins.
        clear_inputs();
        ir = 16'h3000;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            r = (k >= 6);
            sb.push_back(mk(a[k], a[k], 0, 0, 0));
            tick();
            e = sb.pop_front();
            checks++; if (st4 !== e.st4) begin failures++; $display("FAIL timeout_ready step %0d state4 got %0d exp %0d", k, st4, e.st4); end
            checks++; if (f4 !== e.f4) begin failures++; $display("FAIL timeout_ready step %0d fault4 got %b exp %b", k, f4, e.f4); end
            checks++; if (st0 !== e.st0) begin failures++; $display("FAIL timeout_ready step %0d state0 got %0d exp %0d", k, st0, e.st0); end
        end
        // Reset in the middle of a wait must clear the count and raise no fault.
        clear_inputs();
        ir = 16'h3000;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            reset = (k == 5);
            r     = (k == 13);
            sb.push_back(mk(b0[k], b4[k], 0, 0, (k == 12) ? 1 : 0));
            tick();
            e = sb.pop_front();
            checks++; if (st4 !== e.st4) begin failures++; $display("FAIL timeout_reset step %0d state4 got %0d exp %0d", k, st4, e.st4); end
            checks++; if (co4 !== ctrl_of(e.st4)) begin failures++; $display("FAIL timeout_reset step %0d ctrl4 got %h exp %h", k, co4, ctrl_of(e.st4)); end
            checks++; if (f4 !== e.f4) begin failures++; $display("FAIL timeout_reset step %0d fault4 got %b exp %b", k, f4, e.f4); end
            checks++; if (st0 !== e.st0 || f0 !== e.f0) begin failures++; $display("FAIL timeout_reset step %0d dut0 got %0d/%b exp %0d/%b", k, st0, f0, e.st0, e.f0); end
        end
        reset = 1'b0;
    endtask

    task automatic test_branch_conds();
        logic [15:0] irs  [7] = '{16'h5000, 16'h5000, 16'h6000, 16'h6000, 16'h7800, 16'h7000, 16'h9000};
        int          ints [7] = '{1, 0, 0, 1, 0, 0, 0};
        int          prvs [7] = '{0, 1, 1, 0, 0, 0, 0};
        int          ops  [7] = '{5, 5, 6, 6, 7, 7, 9};
        int          mids [7] = '{41, 41, 42, 42, 43, 43, 44};
        int          s3s  [7] = '{16, 0, 8, 0, 1, 0, 18};
        int          s4s  [7] = '{18, 18, 18, 18, 32, 18, 32};
        int          seq  [5];
        exp_t        e;
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            ir   = irs[c];
            intr = 1'(ints[c]);
            priv = 1'(prvs[c]);
            seq  = '{32, ops[c], mids[c], s3s[c], s4s[c]};
            apply_reset();
            for (int k = 0; k < 5; k++) begin
                sb.push_back(mk(seq[k], seq[k], 0, 0, 0));
                tick();
                e = sb.pop_front();
                checks++; if (st0 !== e.st0) begin failures++; $display("FAIL branch case %0d step %0d state0 got %0d exp %0d", c, k, st0, e.st0); end
                checks++; if (co0 !== ctrl_of(e.st0)) begin failures++; $display("FAIL branch case %0d step %0d ctrl0 got %h exp %h", c, k, co0, ctrl_of(e.st0)); end
                checks++; if (st4 !== e.st4) begin failures++; $display("FAIL branch case %0d step %0d state4 got %0d exp %0d", c, k, st4, e.st4); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_ben();
        test_ready_wait();
        test_timeout();
        test_branch_conds();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
